gpu_tex_modulate: RTL and testbench

- Stage directly downstream of the texture/CLUT fetch stage.
- Consumes the fetched texel (BGR555 plus mask bit), the pixel's vertex colour and the screen LSBs.
- Applies PSX texture modulation (texel*colour/128, saturating), or passes the texel or the colour through unchanged, then truncates to RGB555, sets the mask bit and discards transparent texels.
- Two-stage elastic pipeline with valid/ready handshakes on both sides; feeds the blend/write-back stage.

---
 rtl/gpu_pkg.sv | 28 ++
 rtl/gpu_tex_modulate_chan.sv | 85 ++++++++
 rtl/gpu_tex_modulate.sv | 168 ++++++++++++++++
 tb/tb_gpu_tex_modulate.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// gpu_pkg: shared constants for the texture modulation stage.
//   - Pixel field offsets of the packed {mask, B5, G5, R5} word.
//   - Modulation shift (texel*colour >> 7) and saturation value.
//   - PSX 4x4 ordered-dither offset table, indexed [scrY][scrX].
//   - expand5: 5-bit channel to 8-bit by appending three zero LSBs.
package gpu_pkg;

  localparam int PIX_R_LSB    = 0;
  localparam int PIX_G_LSB    = 5;
  localparam int PIX_B_LSB    = 10;
  localparam int PIX_MASK_BIT = 15;

  localparam int         MOD_SHIFT = 7;
  localparam logic [7:0] SAT_VAL   = 8'd255;

  // Rows: -4 0 -3 1 / 2 -2 3 -1 / -3 1 -4 0 / 3 -1 2 -2 (two's complement nibbles).
  localparam logic signed [3:0] DITHER_TBL [4][4] = '{
    '{4'shC, 4'sh0, 4'shD, 4'sh1},
    '{4'sh2, 4'shE, 4'sh3, 4'shF},
    '{4'shD, 4'sh1, 4'shC, 4'sh0},
    '{4'sh3, 4'shF, 4'sh2, 4'shE}
  };

  function automatic logic [7:0] expand5(input logic [4:0] c5);
    return {c5, 3'b000};
  endfunction

endpackage

// File: rtl/gpu_tex_modulate_chan.sv
// gpu_tex_modulate_chan: one colour channel of the modulation stage.
// Stage-1 registers (t8, c8, product) load on 'load'; the stage-2 value is
// produced combinationally from them and registered by the parent.
// Optional macro: GPU_TEXMOD_DITHER_EN adds the ditherOff input and adder.
// Ports:
//   clk, i_nrst      clock, async active-low reset
//   load             stage-1 advance
//   t5 [4:0]         texel channel
//   c8 [7:0]         vertex colour channel
//   untex, raw       stage-1 registered mode flags
//   ditherOff [3:0]  signed offset, already zero when dithering is off (macro only)
//   o5 [4:0]         truncated output channel
module gpu_tex_modulate_chan
  import gpu_pkg::*;
(
  input  logic              clk,
  input  logic              i_nrst,
  input  logic              load,
  input  logic [4:0]        t5,
  input  logic [7:0]        c8,
  input  logic              untex,
  input  logic              raw,
`ifdef GPU_TEXMOD_DITHER_EN
  input  logic signed [3:0] ditherOff,
`endif
  output logic [4:0]        o5
);

  logic [7:0]  t8;
  logic [7:0]  t8Q;
  logic [7:0]  c8Q;
  logic [15:0] prodQ;
  logic [7:0]  modV;
  logic [7:0]  v;
  logic [7:0]  vOut;
  logic        unusedBits;

  assign t8 = expand5(t5);

  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst) begin
      t8Q   <= '0;
      c8Q   <= '0;
      prodQ <= '0;
    end else if (load) begin
      t8Q   <= t8;
      c8Q   <= c8;
      prodQ <= 16'(t8) * 16'(c8);
    end
  end

  // Max product is 248*255, so bit 15 set means the shifted value exceeds 255.
  always_comb begin
    modV = prodQ[15] ? SAT_VAL : prodQ[MOD_SHIFT +: 8];
    if (untex) begin
      v = c8Q;
    end else if (raw) begin
      v = t8Q;
    end else begin
      v = modV;
    end
  end

`ifdef GPU_TEXMOD_DITHER_EN
  logic signed [9:0] vDith;
  always_comb begin
    vDith = $signed({2'b00, v}) + $signed({{6{ditherOff[3]}}, ditherOff});
    // Range is -4..258: bit 9 flags negative, bit 8 flags overflow past 255.
    if (vDith[9]) begin
      vOut = 8'd0;
    end else if (vDith[8]) begin
      vOut = SAT_VAL;
    end else begin
      vOut = vDith[7:0];
    end
  end
`else
  assign vOut = v;
`endif

  assign o5 = vOut[7:3];

  assign unusedBits = ^{prodQ[MOD_SHIFT-1:0], vOut[2:0]};

endmodule

// File: rtl/gpu_tex_modulate.sv
// gpu_tex_modulate: texture modulation stage between texel fetch and blend.
// Two-stage elastic pipeline: stage 1 registers per-channel products and mode
// flags, stage 2 registers the final {mask, B5, G5, R5} pixel.
// Optional macro: GPU_TEXMOD_DITHER_EN adds GPU_REG_Dither and 4x4 dithering.
// Ports:
//   clk, i_nrst                        clock, async active-low reset
//   GPU_REG_RawTexture                 texel used unmodulated
//   GPU_REG_ForceMask                  force output bit 15
//   GPU_TEX_DISABLE                    untextured: colour used directly
//   GPU_REG_Dither                     dither enable (macro only)
//   iValid / oReady                    upstream handshake
//   iScrX, iScrY                       screen LSBs
//   iTexel, iTransparent               texel and its all-zero-colour flag
//   iR, iG, iB                         vertex colour
//   oValid / iReady                    downstream handshake
//   oPixel, oScrX, oScrY               result and delayed screen LSBs
module gpu_tex_modulate
  import gpu_pkg::*;
#(
  parameter bit PIPE_BYPASS_FULL = 1'b1
) (
  input  logic        clk,
  input  logic        i_nrst,
  input  logic        GPU_REG_RawTexture,
  input  logic        GPU_REG_ForceMask,
  input  logic        GPU_TEX_DISABLE,
`ifdef GPU_TEXMOD_DITHER_EN
  input  logic        GPU_REG_Dither,
`endif
  input  logic        iValid,
  output logic        oReady,
  input  logic [1:0]  iScrX,
  input  logic [1:0]  iScrY,
  input  logic [15:0] iTexel,
  input  logic        iTransparent,
  input  logic [7:0]  iR,
  input  logic [7:0]  iG,
  input  logic [7:0]  iB,
  output logic        oValid,
  input  logic        iReady,
  output logic [15:0] oPixel,
  output logic [1:0]  oScrX,
  output logic [1:0]  oScrY
);

  // Handshake: a pixel moves in when iValid & oReady and out when
  // oValid & iReady. Each stage loads when it is empty or the stage after it
  // is advancing; otherwise it holds, so outputs are stable under stall.
  // oReady does not depend on iValid.
  logic s1Valid, s2Valid;
  logic s1Adv, s2Adv;
  logic inXfer, dropIn;

  logic       s1Untex, s1Raw, s1Force, s1Mask;
  logic [1:0] s1ScrX, s1ScrY;
  logic [4:0] r5, g5, b5;
  logic [15:0] pixNext;

  assign s2Adv  = !s2Valid | iReady;
  assign s1Adv  = !s1Valid | s2Adv;
  assign oReady = PIPE_BYPASS_FULL ? s1Adv : !s1Valid;
  assign inXfer = iValid & oReady;
  // Transparent textured texels are consumed but never occupy stage 1.
  assign dropIn = !GPU_TEX_DISABLE & iTransparent;
  assign oValid = s2Valid;

  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst) begin
      s1Valid <= 1'b0;
      s1Untex <= 1'b0;
      s1Raw   <= 1'b0;
      s1Force <= 1'b0;
      s1Mask  <= 1'b0;
      s1ScrX  <= '0;
      s1ScrY  <= '0;
    end else if (s1Adv) begin
      s1Valid <= inXfer & !dropIn;
      s1Untex <= GPU_TEX_DISABLE;
      s1Raw   <= GPU_REG_RawTexture;
      s1Force <= GPU_REG_ForceMask;
      s1Mask  <= GPU_TEX_DISABLE ? 1'b0 : iTexel[PIX_MASK_BIT];
      s1ScrX  <= iScrX;
      s1ScrY  <= iScrY;
    end
  end

`ifdef GPU_TEXMOD_DITHER_EN
  logic              s1Dither;
  logic signed [3:0] ditherOff;

  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst) begin
      s1Dither <= 1'b0;
    end else if (s1Adv) begin
      s1Dither <= GPU_REG_Dither;
    end
  end

  // Raw texels are exempt; untextured pixels are never treated as raw.
  assign ditherOff = (s1Dither && !(s1Raw && !s1Untex)) ?
                     DITHER_TBL[s1ScrY][s1ScrX] : 4'sd0;
`endif

  gpu_tex_modulate_chan u_chanR (
    .clk       (clk),
    .i_nrst    (i_nrst),
    .load      (s1Adv),
    .t5        (iTexel[PIX_R_LSB +: 5]),
    .c8        (iR),
    .untex     (s1Untex),
    .raw       (s1Raw),
`ifdef GPU_TEXMOD_DITHER_EN
    .ditherOff (ditherOff),
`endif
    .o5        (r5)
  );

  gpu_tex_modulate_chan u_chanG (
    .clk       (clk),
    .i_nrst    (i_nrst),
    .load      (s1Adv),
    .t5        (iTexel[PIX_G_LSB +: 5]),
    .c8        (iG),
    .untex     (s1Untex),
    .raw       (s1Raw),
`ifdef GPU_TEXMOD_DITHER_EN
    .ditherOff (ditherOff),
`endif
    .o5        (g5)
  );

  gpu_tex_modulate_chan u_chanB (
    .clk       (clk),
    .i_nrst    (i_nrst),
    .load      (s1Adv),
    .t5        (iTexel[PIX_B_LSB +: 5]),
    .c8        (iB),
    .untex     (s1Untex),
    .raw       (s1Raw),
`ifdef GPU_TEXMOD_DITHER_EN
    .ditherOff (ditherOff),
`endif
    .o5        (b5)
  );

  always_comb begin
    pixNext                  = '0;
    pixNext[PIX_R_LSB +: 5]  = r5;
    pixNext[PIX_G_LSB +: 5]  = g5;
    pixNext[PIX_B_LSB +: 5]  = b5;
    pixNext[PIX_MASK_BIT]    = s1Mask | s1Force;
  end

  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst) begin
      s2Valid <= 1'b0;
      oPixel  <= '0;
      oScrX   <= '0;
      oScrY   <= '0;
    end else if (s2Adv) begin
      s2Valid <= s1Valid;
      oPixel  <= pixNext;
      oScrX   <= s1ScrX;
      oScrY   <= s1ScrY;
    end
  end

endmodule

// File: tb/tb_gpu_tex_modulate.sv
// Testbench for gpu_tex_modulate: directed vectors with hand-computed results.
// Expected entries are {scrY, scrX, pixel}, queued when the input transfer
// happens and checked in order when the output transfer happens.
module tb_gpu_tex_modulate;

  logic        clk;
  logic        i_nrst;
  logic        GPU_REG_RawTexture;
  logic        GPU_REG_ForceMask;
  logic        GPU_TEX_DISABLE;
`ifdef GPU_TEXMOD_DITHER_EN
  logic        GPU_REG_Dither;
`endif
  logic        iValid;
  logic        oReady;
  logic [1:0]  iScrX, iScrY;
  logic [15:0] iTexel;
  logic        iTransparent;
  logic [7:0]  iR, iG, iB;
  logic        oValid;
  logic        iReady;
  logic [15:0] oPixel;
  logic [1:0]  oScrX, oScrY;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int out_cnt = 0;
  bit chk_lat = 1'b1;
  logic [19:0] exp_q[$];
  int          lat_q[$];
  logic [19:0] cur_exp = '0;
  bit          cur_emit = 1'b0;

  gpu_tex_modulate dut (
    .clk                (clk),
    .i_nrst             (i_nrst),
    .GPU_REG_RawTexture (GPU_REG_RawTexture),
    .GPU_REG_ForceMask  (GPU_REG_ForceMask),
    .GPU_TEX_DISABLE    (GPU_TEX_DISABLE),
`ifdef GPU_TEXMOD_DITHER_EN
    .GPU_REG_Dither     (GPU_REG_Dither),
`endif
    .iValid             (iValid),
    .oReady             (oReady),
    .iScrX              (iScrX),
    .iScrY              (iScrY),
    .iTexel             (iTexel),
    .iTransparent       (iTransparent),
    .iR                 (iR),
    .iG                 (iG),
    .iB                 (iB),
    .oValid             (oValid),
    .iReady             (iReady),
    .oPixel             (oPixel),
    .oScrX              (oScrX),
    .oScrY              (oScrY)
  );

  // Clock block
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: sampled on the falling edge, transfers take effect next rise.
  always @(negedge clk) begin
    if (i_nrst) begin
      if (oValid && iReady) begin
        out_cnt++;
        total++;
        assert (exp_q.size() != 0) else begin
          bad++;
          $error("FAIL spurious_out: observed pixel=0x%0h expected no output", oPixel);
        end
        if (exp_q.size() != 0) begin
          logic [19:0] e;
          int l;
          e = exp_q.pop_front();
          l = lat_q.pop_front();
          chk("pixel", {12'b0, oScrY, oScrX, oPixel}, {12'b0, e});
          if (chk_lat) chk("latency", cyc - l, 2);
        end
      end
      if (iValid && oReady && cur_emit) begin
        exp_q.push_back(cur_exp);
        lat_q.push_back(cyc);
      end
    end
  end

  // Driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [15:0] tex, input logic tr,
                      input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                      input logic [1:0] sx, input logic [1:0] sy,
                      input logic [15:0] ex, input bit emit);
    int waits;
    bit acc;
    waits = 0;
    acc = 1'b0;
    iTexel = tex; iTransparent = tr; iR = r; iG = g; iB = b;
    iScrX = sx; iScrY = sy;
    cur_exp = {sy, sx, ex};
    cur_emit = emit;
    iValid = 1'b1;
    while (!acc && waits < 50) begin
      @(negedge clk);
      acc = oReady;
      @(posedge clk);
      #1;
      waits++;
    end
    chk("accept", {31'b0, acc}, 1);
    iValid = 1'b0;
    cur_emit = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 60) begin
      step(1);
      w++;
    end
    step(2);
    chk("drain_empty", exp_q.size(), 0);
  endtask

  // Directed sequence
  initial begin
    int oc;
    logic [15:0] held;
    i_nrst = 1'b0;
    GPU_REG_RawTexture = 1'b0;
    GPU_REG_ForceMask = 1'b0;
    GPU_TEX_DISABLE = 1'b0;
`ifdef GPU_TEXMOD_DITHER_EN
    GPU_REG_Dither = 1'b0;
`endif
    iValid = 1'b0; iReady = 1'b1;
    iScrX = '0; iScrY = '0; iTexel = '0; iTransparent = 1'b0;
    iR = '0; iG = '0; iB = '0;

    #1;
    chk("rst_valid", oValid, 0);
    chk("rst_pixel", oPixel, 16'h0000);
    chk("rst_scrx", oScrX, 0);
    chk("rst_scry", oScrY, 0);
    step(2);
    i_nrst = 1'b1;
    step(1);
    chk("idle_ready", oReady, 1);

    // Identity, saturation, plain modulation, raw
    send(16'h7FFF, 0, 8'h80, 8'h80, 8'h80, 2'd1, 2'd2, 16'h7FFF, 1);
    send(16'h001F, 0, 8'hFF, 8'h80, 8'h80, 2'd2, 2'd0, 16'h001F, 1);
    send(16'h001F, 0, 8'h40, 8'h80, 8'h80, 2'd3, 2'd1, 16'h000F, 1);
    GPU_REG_RawTexture = 1'b1;
    send(16'h001F, 0, 8'h40, 8'h80, 8'h80, 2'd0, 2'd3, 16'h001F, 1);
    GPU_REG_RawTexture = 1'b0;  // pixel already in stage 1 stays raw
    send(16'h7D50, 0, 8'hC0, 8'h20, 8'h00, 2'd1, 2'd1, 16'h0058, 1);
    drain();

    // Transparent textured texel is dropped; next pixel unaffected
    oc = out_cnt;
    send(16'h0000, 1, 8'h80, 8'h80, 8'h80, 2'd0, 2'd0, 16'h0000, 0);
    send(16'h7FFF, 0, 8'h80, 8'h80, 8'h80, 2'd3, 2'd3, 16'h7FFF, 1);
    drain();
    chk("drop_count", out_cnt - oc, 1);

    // Untextured: colour passes, texel mask ignored, transparency ignored
    GPU_TEX_DISABLE = 1'b1;
    send(16'h8000, 1, 8'h18, 8'h08, 8'hF8, 2'd2, 2'd1, 16'h7C23, 1);
    GPU_TEX_DISABLE = 1'b0;
    drain();

    // Mask bit from texel, forced, then force cleared
    send(16'h8421, 0, 8'h80, 8'h80, 8'h80, 2'd0, 2'd1, 16'h8421, 1);
    GPU_REG_ForceMask = 1'b1;
    send(16'h0421, 0, 8'h80, 8'h80, 8'h80, 2'd1, 2'd0, 16'h8421, 1);
    GPU_REG_ForceMask = 1'b0;
    send(16'h0421, 0, 8'h80, 8'h80, 8'h80, 2'd2, 2'd2, 16'h0421, 1);
    drain();

    // Backpressure: six pixels, iReady low for five cycles
    chk_lat = 1'b0;
    oc = out_cnt;
    fork
      begin
        for (int i = 1; i <= 6; i++)
          send(16'(i) * 16'h0421, 0, 8'h80, 8'h80, 8'h80, 2'(i), 2'(i + 1),
               16'(i) * 16'h0421, 1);
      end
      begin
        step(3);
        iReady = 1'b0;
        step(2);
        @(negedge clk);
        held = oPixel;
        chk("stall_ready_low", oReady, 0);
        chk("stall_valid", oValid, 1);
        step(2);
        @(negedge clk);
        chk("stall_hold", oPixel, held);
        chk("stall_ready_low2", oReady, 0);
        step(1);
        iReady = 1'b1;
      end
    join
    drain();
    chk("stream_count", out_cnt - oc, 6);
    chk_lat = 1'b1;

    // Reset with two pixels in flight
    oc = out_cnt;
    send(16'h0421, 0, 8'h80, 8'h80, 8'h80, 2'd1, 2'd1, 16'h0421, 1);
    send(16'h0842, 0, 8'h80, 8'h80, 8'h80, 2'd2, 2'd2, 16'h0842, 1);
    chk("inflight_valid", oValid, 1);
    i_nrst = 1'b0;
    #1;
    chk("midrst_valid", oValid, 0);
    chk("midrst_pixel", oPixel, 16'h0000);
    exp_q.delete();
    lat_q.delete();
    step(2);
    i_nrst = 1'b1;
    step(6);
    chk("midrst_no_out", out_cnt - oc, 0);
    chk("midrst_valid_after", oValid, 0);

`ifdef GPU_TEXMOD_DITHER_EN
    // Dither: 2 + (-2) = 0 at (1,1); 254 + 3 clamps to 255 at (0,3)
    GPU_REG_Dither = 1'b1;
    GPU_TEX_DISABLE = 1'b1;
    send(16'h0000, 1, 8'h02, 8'h02, 8'h02, 2'd1, 2'd1, 16'h0000, 1);
    send(16'h0000, 1, 8'hFE, 8'hFE, 8'hFE, 2'd0, 2'd3, 16'h7FFF, 1);
    drain();
    GPU_REG_Dither = 1'b0;
    GPU_TEX_DISABLE = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
